instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 594 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Byte-code instruction sequencer: fetches opcode and argument bytes, pops operands,
// runs the execute unit, writes back and advances the PC. Optional SEQ_INSTR_COUNT_EN adds instr_count.
module instr_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] start_pc,
  output logic        prog_rd,
  output logic [15:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic        prog_valid,
  output logic [7:0]  opcode,
  input  logic [1:0]  argc,
  input  logic [1:0]  stackargs,
  input  logic        stackwb,
  input  logic        isgoto,
  input  logic        iscmp,
  output logic        pop,
  output logic        push,
  input  logic        stack_empty,
  output logic        exec_start,
  input  logic        exec_done,
  input  logic        cmp_taken,
  output logic [15:0] args,
  output logic [15:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        fault
`ifdef SEQ_INSTR_COUNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_OP, S_FETCH_ARG, S_POP, S_EXEC, S_WB, S_NEXT, S_HALT
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [7:0]  r_opcode;
  logic [15:0] r_args;
  logic        r_prog_rd;
  logic [15:0] r_prog_addr;
  logic        r_push;
  logic        r_exec_start;
  logic        r_halted;
  logic        r_fault;
  logic [1:0]  r_cnt;
  logic        r_cmp_taken;

  logic [1:0]  w_argc;
  logic        w_arg_done;
  logic        w_pop_done;
  logic        w_pop;
  logic        w_taken;
  logic        w_halt_op;
  logic [15:0] w_offset;
  logic [15:0] w_next_pc;
  logic [15:0] w_arg_addr;

  assign w_argc     = (argc == 2'd3) ? 2'd2 : argc;
  assign w_arg_done = (r_cnt == w_argc);
  assign w_pop_done = (r_cnt == stackargs);
  assign w_halt_op  = (prog_data == 8'hAC) || (prog_data == 8'hB0) || (prog_data == 8'hB1);
  assign w_taken    = isgoto || (iscmp && r_cmp_taken);
  // A single argument byte is an 8-bit signed offset; two bytes are already 16-bit.
  assign w_offset   = (w_argc == 2'd1) ? {{8{r_args[7]}}, r_args[7:0]} : r_args;
  assign w_next_pc  = w_taken ? (r_pc + w_offset) : (r_pc + 16'd1 + {14'd0, w_argc});
  assign w_arg_addr = r_pc + 16'd1 + {14'd0, r_cnt};

  // Pop is gated by the live stack_empty so a pulse is never issued against an empty stack.
  assign w_pop      = (r_state == S_POP) && !w_pop_done && !stack_empty;

  assign prog_rd    = r_prog_rd;
  assign prog_addr  = r_prog_addr;
  assign opcode     = r_opcode;
  assign args       = r_args;
  assign pc         = r_pc;
  assign pop        = w_pop;
  assign push       = r_push;
  assign exec_start = r_exec_start;
  assign halted     = r_halted;
  assign fault      = r_fault;
  assign busy       = (r_state != S_IDLE) && (r_state != S_HALT);

`ifdef SEQ_INSTR_COUNT_EN
  logic [31:0] r_instr_count;
  assign instr_count = r_instr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_count <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_instr_count <= '0;
    end else if (r_state == S_NEXT) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end
`endif

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_opcode     <= '0;
      r_args       <= '0;
      r_prog_rd    <= 1'b0;
      r_prog_addr  <= '0;
      r_push       <= 1'b0;
      r_exec_start <= 1'b0;
      r_halted     <= 1'b0;
      r_fault      <= 1'b0;
      r_cnt        <= '0;
      r_cmp_taken  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pc        <= start_pc;
            r_args      <= '0;
            r_prog_rd   <= 1'b1;
            r_prog_addr <= start_pc;
            r_state     <= S_FETCH_OP;
          end
        end
        S_FETCH_OP: begin
          if (r_prog_rd && prog_valid) begin
            r_prog_rd <= 1'b0;
            r_opcode  <= prog_data;
            if (w_halt_op) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_args  <= '0;
              r_cnt   <= '0;
              r_state <= S_FETCH_ARG;
            end
          end
        end
        // The first cycle here has no read pending, which gives the decoder a cycle to settle.
        S_FETCH_ARG: begin
          if (r_prog_rd) begin
            if (prog_valid) begin
              r_prog_rd <= 1'b0;
              r_args    <= {r_args[7:0], prog_data};
              r_cnt     <= r_cnt + 2'd1;
            end
          end else if (!w_arg_done) begin
            r_prog_rd   <= 1'b1;
            r_prog_addr <= w_arg_addr;
          end else begin
            r_cnt <= '0;
            if (stackargs == 2'd0) begin
              r_exec_start <= 1'b1;
              r_state      <= S_EXEC;
            end else begin
              r_state <= S_POP;
            end
          end
        end
        S_POP: begin
          if (w_pop_done) begin
            r_cnt        <= '0;
            r_exec_start <= 1'b1;
            r_state      <= S_EXEC;
          end else if (stack_empty) begin
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_EXEC: begin
          r_exec_start <= 1'b0;
          if (exec_done && !r_exec_start) begin
            r_cmp_taken <= cmp_taken;
            if (stackwb) begin
              r_push  <= 1'b1;
              r_state <= S_WB;
            end else begin
              r_state <= S_NEXT;
            end
          end
        end
        S_WB: begin
          r_push  <= 1'b0;
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          r_pc        <= w_next_pc;
          r_prog_rd   <= 1'b1;
          r_prog_addr <= w_next_pc;
          r_state     <= S_FETCH_OP;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: program memory, decoder, stack and execute-unit
// models feed an event scoreboard (fetch addresses and strobes) checked per scenario.
module tb_instr_sequencer;

  localparam logic [1:0] EV_FETCH = 2'd0;
  localparam logic [1:0] EV_POP   = 2'd1;
  localparam logic [1:0] EV_EXEC  = 2'd2;
  localparam logic [1:0] EV_PUSH  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] start_pc;
  logic        prog_rd;
  logic [15:0] prog_addr;
  logic [7:0]  prog_data;
  logic        prog_valid;
  logic [7:0]  opcode;
  logic [1:0]  argc;
  logic [1:0]  stackargs;
  logic        stackwb;
  logic        isgoto;
  logic        iscmp;
  logic        pop;
  logic        push;
  logic        stack_empty;
  logic        exec_start;
  logic        exec_done;
  logic        cmp_taken;
  logic [15:0] args;
  logic [15:0] pc;
  logic        busy;
  logic        halted;
  logic        fault;
`ifdef SEQ_INSTR_COUNT_EN
  logic [31:0] instr_count;
`endif

  logic [7:0] mem [0:65535];
  int         mem_lat;
  int         exec_lat;
  logic       cmp_val;
  logic       spurious_valid;
  logic       spurious_done;
  int         mem_wait;
  bit         exec_pend;
  int         exec_wait;
  int         excl_cnt;
  ev_t        exp_q[$];
  ev_t        obs_q[$];
  int         n_tests;
  int         n_fail;

  instr_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_pc   (start_pc),
    .prog_rd    (prog_rd),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_valid (prog_valid),
    .opcode     (opcode),
    .argc       (argc),
    .stackargs  (stackargs),
    .stackwb    (stackwb),
    .isgoto     (isgoto),
    .iscmp      (iscmp),
    .pop        (pop),
    .push       (push),
    .stack_empty(stack_empty),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .cmp_taken  (cmp_taken),
    .args       (args),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault)
`ifdef SEQ_INSTR_COUNT_EN
    ,
    .instr_count(instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decoder model
  always_comb begin
    argc      = 2'd0;
    stackargs = 2'd0;
    stackwb   = 1'b0;
    isgoto    = 1'b0;
    iscmp     = 1'b0;
    case (opcode)
      8'h10: begin argc = 2'd1; stackwb = 1'b1; end
      8'h60: begin stackargs = 2'd2; stackwb = 1'b1; end
      8'h57: stackargs = 2'd1;
      8'h9F: begin argc = 2'd2; stackargs = 2'd2; iscmp = 1'b1; end
      8'hA7: begin argc = 2'd2; isgoto = 1'b1; end
      8'hC4: argc = 2'd3;
      default: ;
    endcase
  end

  // Memory / execute-unit models and strobe monitor, all on the falling edge.
  initial begin
    prog_valid = 1'b0;
    prog_data  = 8'h00;
    exec_done  = 1'b0;
    cmp_taken  = 1'b0;
    mem_wait   = 0;
    exec_pend  = 1'b0;
    exec_wait  = 0;
    excl_cnt   = 0;
    forever begin
      @(negedge clk);
      if (pop)        obs_q.push_back('{EV_POP, 16'h0});
      if (exec_start) obs_q.push_back('{EV_EXEC, 16'h0});
      if (push)       obs_q.push_back('{EV_PUSH, 16'h0});
      if (int'(pop) + int'(push) + int'(exec_start) + int'(prog_rd) > 1) excl_cnt++;

      prog_valid = 1'b0;
      if (spurious_valid) begin
        prog_valid = 1'b1;
        prog_data  = 8'hB1;
      end else if (prog_rd) begin
        if (mem_wait >= mem_lat) begin
          prog_valid = 1'b1;
          prog_data  = mem[prog_addr];
          mem_wait   = 0;
          obs_q.push_back('{EV_FETCH, prog_addr});
        end else begin
          mem_wait++;
        end
      end else begin
        mem_wait = 0;
      end

      exec_done = 1'b0;
      cmp_taken = 1'b0;
      if (exec_pend) begin
        if (exec_wait == 0) begin
          exec_done = 1'b1;
          cmp_taken = cmp_val;
          exec_pend = 1'b0;
        end else begin
          exec_wait--;
        end
      end
      if (spurious_done) exec_done = 1'b1;
      if (exec_start) begin
        exec_pend = 1'b1;
        exec_wait = exec_lat;
      end
    end
  end

  task automatic exp_ev(input logic [1:0] kind, input logic [15:0] val);
    exp_q.push_back('{kind, val});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n          = 1'b0;
    start          = 1'b0;
    start_pc       = 16'h0;
    stack_empty    = 1'b0;
    cmp_val        = 1'b0;
    spurious_valid = 1'b0;
    spurious_done  = 1'b0;
    mem_lat        = 0;
    exec_lat       = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic start_prog(input logic [15:0] addr);
    start_pc = addr;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      @(posedge clk); #1;
    end
    n_tests++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL %s halt timeout: halted=%b, expected 1 within %0d cycles", name, halted, budget);
    end
  endtask

  task automatic sb_drain(input string name);
    ev_t e;
    ev_t o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s missing event: got none, expected kind=%0d val=%h", name, e.kind, e.val);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s event: got kind=%0d val=%h, expected kind=%0d val=%h",
                   name, o.kind, o.val, e.kind, e.val);
        end
      end
    end
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s extra events: got %0d (first kind=%0d val=%h), expected 0",
               name, obs_q.size(), obs_q[0].kind, obs_q[0].val);
    end
    obs_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({pc, opcode, args, prog_addr, prog_rd, pop, push, exec_start, busy, halted, fault} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h op=%h args=%h addr=%h rd=%b pop=%b push=%b xs=%b busy=%b h=%b f=%b, expected all 0",
               pc, opcode, args, prog_addr, prog_rd, pop, push, exec_start, busy, halted, fault);
    end
  endtask

  task automatic test_bipush();
    do_reset();
    mem[16'h0010] = 8'h10;
    mem[16'h0011] = 8'h2A;
    mem[16'h0012] = 8'hB1;
    exp_ev(EV_FETCH, 16'h0010);
    exp_ev(EV_FETCH, 16'h0011);
    exp_ev(EV_EXEC, 16'h0);
    exp_ev(EV_PUSH, 16'h0);
    exp_ev(EV_FETCH, 16'h0012);
    start_prog(16'h0010);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bipush busy: got %b, expected 1", busy);
    end
    wait_halt("bipush", 100);
    sb_drain("bipush");
    n_tests++;
    if (args !== 16'h002A || pc !== 16'h0012) begin
      n_fail++;
      $display("FAIL bipush result: args=%h pc=%h, expected args=002a pc=0012", args, pc);
    end
  endtask

  task automatic test_iadd();
    do_reset();
    mem[16'h0040] = 8'h60;
    mem[16'h0041] = 8'hB1;
    exp_ev(EV_FETCH, 16'h0040);
    exp_ev(EV_POP, 16'h0);
    exp_ev(EV_POP, 16'h0);
    exp_ev(EV_EXEC, 16'h0);
    exp_ev(EV_PUSH, 16'h0);
    exp_ev(EV_FETCH, 16'h0041);
    start_prog(16'h0040);
    wait_halt("iadd", 100);
    sb_drain("iadd");
    n_tests++;
    if (pc !== 16'h0041) begin
      n_fail++;
      $display("FAIL iadd pc: got %h, expected 0041", pc);
    end
  endtask

  task automatic test_goto();
    do_reset();
    mem_lat = 3;
    mem[16'h0020] = 8'hA7;
    mem[16'h0021] = 8'hFF;
    mem[16'h0022] = 8'hFC;
    mem[16'h001C] = 8'hB1;
    exp_ev(EV_FETCH, 16'h0020);
    exp_ev(EV_FETCH, 16'h0021);
    exp_ev(EV_FETCH, 16'h0022);
    exp_ev(EV_EXEC, 16'h0);
    exp_ev(EV_FETCH, 16'h001C);
    start_prog(16'h0020);
    wait_halt("goto", 200);
    sb_drain("goto");
    n_tests++;
    if (pc !== 16'h001C || args !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL goto result: pc=%h args=%h, expected pc=001c args=fffc", pc, args);
    end
  endtask

  task automatic test_cmp();
    logic [15:0] exp_pc;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      cmp_val = (t == 1);
      exp_pc  = (t == 1) ? 16'h0038 : 16'h0033;
      mem[16'h0030] = 8'h9F;
      mem[16'h0031] = 8'h00;
      mem[16'h0032] = 8'h08;
      mem[16'h0033] = 8'hB1;
      mem[16'h0038] = 8'hB1;
      exp_ev(EV_FETCH, 16'h0030);
      exp_ev(EV_FETCH, 16'h0031);
      exp_ev(EV_FETCH, 16'h0032);
      exp_ev(EV_POP, 16'h0);
      exp_ev(EV_POP, 16'h0);
      exp_ev(EV_EXEC, 16'h0);
      exp_ev(EV_FETCH, exp_pc);
      start_prog(16'h0030);
      wait_halt("cmp", 100);
      sb_drain("cmp");
      n_tests++;
      if (pc !== exp_pc) begin
        n_fail++;
        $display("FAIL cmp pc (taken=%0d): got %h, expected %h", t, pc, exp_pc);
      end
    end
  endtask

  task automatic test_fault();
    do_reset();
    stack_empty = 1'b1;
    mem[16'h0050] = 8'h57;
    exp_ev(EV_FETCH, 16'h0050);
    start_prog(16'h0050);
    wait_halt("fault", 100);
    sb_drain("fault");
    n_tests++;
    if (fault !== 1'b1 || halted !== 1'b1 || busy !== 1'b0 || pc !== 16'h0050) begin
      n_fail++;
      $display("FAIL fault flags: fault=%b halted=%b busy=%b pc=%h, expected 1 1 0 0050", fault, halted, busy, pc);
    end
  endtask

  task automatic test_halt_ops();
    logic [7:0] ops [3];
    ops[0] = 8'hAC;
    ops[1] = 8'hB0;
    ops[2] = 8'hB1;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      mem[16'h0060 + 16'(i)] = ops[i];
      exp_ev(EV_FETCH, 16'h0060 + 16'(i));
      start_prog(16'h0060 + 16'(i));
      wait_halt("halt_op", 50);
      sb_drain("halt_op");
      // HALT must hold even if start is pulsed again.
      start_prog(16'h0000);
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (halted !== 1'b1 || fault !== 1'b0 || opcode !== ops[i] || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_op %h: halted=%b fault=%b opcode=%h busy=%b, expected 1 0 %h 0",
                 ops[i], halted, fault, opcode, busy, ops[i]);
      end
      sb_drain("halt_hold");
    end
  endtask

  task automatic test_wrap();
    do_reset();
    mem[16'hFFFE] = 8'hC4;
    mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12;
    mem[16'h0001] = 8'hB1;
    exp_ev(EV_FETCH, 16'hFFFE);
    exp_ev(EV_FETCH, 16'hFFFF);
    exp_ev(EV_FETCH, 16'h0000);
    exp_ev(EV_EXEC, 16'h0);
    exp_ev(EV_FETCH, 16'h0001);
    start_prog(16'hFFFE);
    wait_halt("argc3_wrap", 100);
    sb_drain("argc3_wrap");
    n_tests++;
    if (pc !== 16'h0001 || args !== 16'h3412) begin
      n_fail++;
      $display("FAIL argc3_wrap result: pc=%h args=%h, expected pc=0001 args=3412", pc, args);
    end
    do_reset();
    mem[16'hFFFF] = 8'h00;
    mem[16'h0000] = 8'hB1;
    exp_ev(EV_FETCH, 16'hFFFF);
    exp_ev(EV_EXEC, 16'h0);
    exp_ev(EV_FETCH, 16'h0000);
    start_prog(16'hFFFF);
    wait_halt("pc_wrap", 100);
    sb_drain("pc_wrap");
    n_tests++;
    if (pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL pc_wrap pc: got %h, expected 0000", pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_lat  = 2;
    exec_lat = 3;
    mem[16'h0100] = 8'h10;
    mem[16'h0101] = 8'h05;
    mem[16'h0102] = 8'h60;
    mem[16'h0103] = 8'h00;
    mem[16'h0104] = 8'hA7;
    mem[16'h0105] = 8'h00;
    mem[16'h0106] = 8'h04;
    mem[16'h0108] = 8'hB1;
    exp_ev(EV_FETCH, 16'h0100);
    exp_ev(EV_FETCH, 16'h0101);
    exp_ev(EV_EXEC, 16'h0);
    exp_ev(EV_PUSH, 16'h0);
    exp_ev(EV_FETCH, 16'h0102);
    exp_ev(EV_POP, 16'h0);
    exp_ev(EV_POP, 16'h0);
    exp_ev(EV_EXEC, 16'h0);
    exp_ev(EV_PUSH, 16'h0);
    exp_ev(EV_FETCH, 16'h0103);
    exp_ev(EV_EXEC, 16'h0);
    exp_ev(EV_FETCH, 16'h0104);
    exp_ev(EV_FETCH, 16'h0105);
    exp_ev(EV_FETCH, 16'h0106);
    exp_ev(EV_EXEC, 16'h0);
    exp_ev(EV_FETCH, 16'h0108);
    start_prog(16'h0100);
    wait_halt("back_to_back", 400);
    sb_drain("back_to_back");
    n_tests++;
    if (pc !== 16'h0108 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back result: pc=%h fault=%b, expected pc=0108 fault=0", pc, fault);
    end
`ifdef SEQ_INSTR_COUNT_EN
    n_tests++;
    if (instr_count !== 32'd4) begin
      n_fail++;
      $display("FAIL instr_count: got %0d, expected 4", instr_count);
    end
`endif
  endtask

  task automatic test_spurious_done();
    do_reset();
    mem_lat = 4;
    mem[16'h0200] = 8'h00;
    mem[16'h0201] = 8'hB1;
    exp_ev(EV_FETCH, 16'h0200);
    exp_ev(EV_EXEC, 16'h0);
    exp_ev(EV_FETCH, 16'h0201);
    start_prog(16'h0200);
    spurious_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    spurious_done = 1'b0;
    wait_halt("spurious_done", 200);
    sb_drain("spurious_done");
    n_tests++;
    if (pc !== 16'h0201) begin
      n_fail++;
      $display("FAIL spurious_done pc: got %h, expected 0201", pc);
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    mem_lat = 5;
    mem[16'h0300] = 8'h00;
    start_prog(16'h0300);
    @(posedge clk); #1;
    n_tests++;
    if (prog_rd !== 1'b1 || prog_addr !== 16'h0300) begin
      n_fail++;
      $display("FAIL midfetch pending: rd=%b addr=%h, expected 1 0300", prog_rd, prog_addr);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({pc, opcode, args, prog_addr, prog_rd, pop, push, exec_start, busy, halted, fault} !== '0) begin
      n_fail++;
      $display("FAIL midfetch reset: pc=%h op=%h addr=%h rd=%b busy=%b, expected all 0",
               pc, opcode, prog_addr, prog_rd, busy);
    end
    @(posedge clk); #1;
    rst_n          = 1'b1;
    spurious_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    spurious_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || opcode !== 8'h00 || halted !== 1'b0 || prog_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL late_valid: busy=%b opcode=%h halted=%b rd=%b, expected 0 00 0 0",
               busy, opcode, halted, prog_rd);
    end
    exp_q.delete();
    sb_drain("late_valid");
  endtask

  task automatic test_reset_midexec();
    bit seen;
    do_reset();
    exec_lat = 6;
    mem[16'h0310] = 8'h00;
    exp_ev(EV_FETCH, 16'h0310);
    exp_ev(EV_EXEC, 16'h0);
    start_prog(16'h0310);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exec_start) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midexec exec_start: got 0, expected 1 within 20 cycles");
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({pc, opcode, args, prog_addr, prog_rd, pop, push, exec_start, busy, halted, fault} !== '0) begin
      n_fail++;
      $display("FAIL midexec reset: pc=%h op=%h busy=%b xs=%b, expected all 0", pc, opcode, busy, exec_start);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || push !== 1'b0 || pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL late_done: busy=%b push=%b pc=%h, expected 0 0 0000", busy, push, pc);
    end
    sb_drain("midexec");
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    start          = 1'b0;
    start_pc       = 16'h0;
    stack_empty    = 1'b0;
    cmp_val        = 1'b0;
    spurious_valid = 1'b0;
    spurious_done  = 1'b0;
    mem_lat        = 0;
    exec_lat       = 0;
    repeat (2) @(posedge clk);

    test_reset();
    test_bipush();
    test_iadd();
    test_goto();
    test_cmp();
    test_fault();
    test_halt_ops();
    test_wrap();
    test_back_to_back();
    test_spurious_done();
    test_reset_midfetch();
    test_reset_midexec();

    n_tests++;
    if (excl_cnt != 0) begin
      n_fail++;
      $display("FAIL strobe_exclusive: got %0d overlapping cycles, expected 0", excl_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
